line_cache: RTL
===============

LINE_CACHE -- requirements
Module: line_cache

Interface
REQ-001 Parameter: LINES, 4, number of direct-mapped lines (power of 2, >=2); line = 4 x 16-bit words.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 cpu_read  input  1  CPU word-read request; held stable until cpu_done.
REQ-005 cpu_write  input  1  CPU word-write request; held stable until cpu_done.
REQ-006 cpu_address  input  16  word address.
REQ-007 cpu_wdata  input  16  write word.
REQ-008 cpu_rdata  output  16  read word; valid while cpu_done=1 for a read.
REQ-009 cpu_done  output  1  request-complete strobe.
REQ-010 mem_readM  output  1  line-read request to memory.
REQ-011 mem_writeM  output  1  line-write request to memory.
REQ-012 mem_address  output  16  line base address, {tag,index,2'b00}.
REQ-013 mem_data  inout  64  line bus; word w at bits [16w+15:16w]; driven only while mem_writeM=1, else Z.
REQ-014 mem_readyM  input  1  memory idle; request accepted at posedge where request && mem_readyM.
REQ-015 mem_input_readyM  input  1  one-cycle read-data-valid on mem_data.
REQ-016 mem_doneM  input  1  one-cycle operation-complete pulse.
REQ-017 hit_count, miss_count  output  16 each  performance counters.

Function
REQ-018 Address split: offset=[1:0], index=[1+log2(LINES):2], tag=remaining upper bits; per line store valid, tag, 64-bit data.
REQ-019 Policy: write-through, write-allocate; cache never holds dirty data.
REQ-020 States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
REQ-021 IDLE, read hit: cpu_rdata=line word, cpu_done=1 combinationally same cycle; hit_count+1; stay IDLE.
REQ-022 IDLE, read miss: latch request; miss_count+1; -> RD_REQ.
REQ-023 IDLE, write hit: merge cpu_wdata into cached line at offset; hit_count+1; -> WR_REQ.
REQ-024 IDLE, write miss: miss_count+1; -> RD_REQ with pending-write flag.
REQ-025 cpu_read and cpu_write both high: read served, write ignored.
REQ-026 Counters increment exactly once per request, on the IDLE evaluation cycle; wrap 0xFFFF->0x0000.
REQ-027 RD_REQ: mem_readM=1, mem_address=line base; on acceptance edge -> RD_WAIT; mem_readM=0 from next cycle.
REQ-028 RD_WAIT: on mem_input_readyM, write mem_data into line, set tag, valid=1 (old line overwritten).
REQ-029 Fill for read: same cycle cpu_rdata=mem_data word at offset, cpu_done=1; -> IDLE.
REQ-030 Fill for write: store line with cpu_wdata merged at offset; -> WR_REQ; no cpu_done.
REQ-031 WR_REQ: mem_writeM=1, mem_address=line base, mem_data=updated line; on acceptance edge -> WR_WAIT, mem_writeM=0 next cycle.
REQ-032 WR_WAIT: on mem_doneM, cpu_done=1 that cycle; -> IDLE.
REQ-033 cpu_done is high only in cycles listed in REQ-021/029/032; never two consecutive cycles for one miss.
REQ-034 No dependence on exact memory latency; waits indefinitely for mem_readyM/mem_input_readyM/mem_doneM.
REQ-035 mem_input_readyM/mem_doneM outside RD_WAIT/WR_WAIT ignored.
REQ-036 At most one memory request outstanding; mem_readM and mem_writeM never both 1.

Reset
REQ-037 reset=1 at posedge: state IDLE, all valid=0, counters 0, pending flag 0.
REQ-038 During/after reset: cpu_done=0, cpu_rdata=0, mem_readM=0, mem_writeM=0, mem_address=0, mem_data=Z.
REQ-039 Reset mid-transaction abandons it; late memory strobes ignored per REQ-035.

Verification
REQ-040 Reset, read 0x0023 -> mem_readM addr 0x0020, on fill cpu_done=1, cpu_rdata=mem[0x0023], miss_count=1.
REQ-041 Then read 0x0022 -> cpu_done same cycle, cpu_rdata=mem[0x0022], hit_count=1, no mem request.
REQ-042 Write 0x0021=0xABCD (hit) -> mem_writeM addr 0x0020, mem_data[31:16]=0xABCD, other words unchanged; cpu_done on mem_doneM; read 0x0021 hits, returns 0xABCD.
REQ-043 Write miss 0x0105=0x1234 -> read line 0x0104, then write line 0x0104 with word1=0x1234; miss_count+1 only.
REQ-044 Conflict: read 0x0020, 0x0060, 0x0020 (LINES=4) -> three misses, three fills.
REQ-045 Reset asserted in RD_WAIT, later mem_input_readyM pulse -> no cpu_done, line invalid, counters 0.

Source files
------------

// File: rtl/line_cache.sv
// Direct-mapped, write-through, write-allocate cache of 4-word lines sitting
// between a word-addressed CPU port and a line-wide memory port.
module line_cache #(
    parameter int LINES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_done,
    output logic        mem_readM,
    output logic        mem_writeM,
    output logic [15:0] mem_address,
    inout  wire  [63:0] mem_data,
    input  logic        mem_readyM,
    input  logic        mem_input_readyM,
    input  logic        mem_doneM,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 14 - IW;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    state_t            state, state_nxt;
    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tag_mem  [LINES];
    logic [63:0]       data_mem [LINES];
    logic [15:0]       req_addr;
    logic [15:0]       req_wdata;
    logic              pend_write;
    logic              hit_inc, miss_inc;

    logic [IW-1:0]     cpu_index, req_index;
    logic [TW-1:0]     cpu_tag, req_tag;
    logic [1:0]        cpu_off, req_off;
    logic              hit;
    logic [15:0]       line_base;

    assign cpu_index = cpu_address[IW+1:2];
    assign cpu_tag   = cpu_address[15:IW+2];
    assign cpu_off   = cpu_address[1:0];
    assign req_index = req_addr[IW+1:2];
    assign req_tag   = req_addr[15:IW+2];
    assign req_off   = req_addr[1:0];
    assign hit       = valid[cpu_index] && (tag_mem[cpu_index] == cpu_tag);
    assign line_base = {req_addr[15:2], 2'b00};

    function automatic logic [15:0] word_of(input logic [63:0] line, input logic [1:0] off);
        logic [15:0] w;
        case (off)
            2'd0:    w = line[15:0];
            2'd1:    w = line[31:16];
            2'd2:    w = line[47:32];
            default: w = line[63:48];
        endcase
        return w;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] line, input logic [1:0] off,
                                          input logic [15:0] w);
        logic [63:0] r;
        r = line;
        case (off)
            2'd0:    r[15:0]  = w;
            2'd1:    r[31:16] = w;
            2'd2:    r[47:32] = w;
            default: r[63:48] = w;
        endcase
        return r;
    endfunction

    // The line is only driven onto the shared bus while a write request is up.
    assign mem_data = mem_writeM ? data_mem[req_index] : 64'bz;

    always_comb begin
        state_nxt   = state;
        cpu_done    = 1'b0;
        cpu_rdata   = 16'h0000;
        mem_readM   = 1'b0;
        mem_writeM  = 1'b0;
        mem_address = 16'h0000;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_read) begin
                    if (hit) begin
                        cpu_done  = 1'b1;
                        cpu_rdata = word_of(data_mem[cpu_index], cpu_off);
                        hit_inc   = 1'b1;
                    end else begin
                        miss_inc  = 1'b1;
                        state_nxt = RD_REQ;
                    end
                end else if (cpu_write) begin
                    if (hit) begin
                        hit_inc   = 1'b1;
                        state_nxt = WR_REQ;
                    end else begin
                        miss_inc  = 1'b1;
                        state_nxt = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                mem_readM   = 1'b1;
                mem_address = line_base;
                if (mem_readyM) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_input_readyM) begin
                    if (pend_write) begin
                        state_nxt = WR_REQ;
                    end else begin
                        cpu_done  = 1'b1;
                        cpu_rdata = word_of(mem_data, req_off);
                        state_nxt = IDLE;
                    end
                end
            end
            WR_REQ: begin
                mem_writeM  = 1'b1;
                mem_address = line_base;
                if (mem_readyM) state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                if (mem_doneM) begin
                    cpu_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Keep every output quiet while reset is held, whatever the stale state.
        if (reset) begin
            state_nxt   = IDLE;
            cpu_done    = 1'b0;
            cpu_rdata   = 16'h0000;
            mem_readM   = 1'b0;
            mem_writeM  = 1'b0;
            mem_address = 16'h0000;
            hit_inc     = 1'b0;
            miss_inc    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
            pend_write <= 1'b0;
            req_addr   <= 16'h0000;
            req_wdata  <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (hit_inc)  hit_count  <= hit_count + 16'd1;
            if (miss_inc) miss_count <= miss_count + 16'd1;
            if (state == IDLE && (cpu_read || cpu_write)) begin
                req_addr   <= cpu_address;
                req_wdata  <= cpu_wdata;
                pend_write <= cpu_write && !cpu_read;
            end
            if (state == IDLE && !cpu_read && cpu_write && hit)
                data_mem[cpu_index] <= merge(data_mem[cpu_index], cpu_off, cpu_wdata);
            if (state == RD_WAIT && mem_input_readyM) begin
                valid[req_index]    <= 1'b1;
                tag_mem[req_index]  <= req_tag;
                data_mem[req_index] <= pend_write ? merge(mem_data, req_off, req_wdata) : mem_data;
            end
        end
    end
endmodule
